// File: rtl/regfile_scoreboard_pkg.sv
// Shared widths, bus layout and helpers for the register file / scoreboard slice.
// Writeback bus is {we, waddr, wdata}; register 0 is hard-wired to zero.
package regfile_scoreboard_pkg;

    localparam int WS_TO_RF_BUS_WD = 38;
    localparam int WE_BIT          = 37;
    localparam int WADDR_HI        = 36;
    localparam int WADDR_LO        = 32;
    localparam int WDATA_HI        = 31;
    localparam int REG_NUM         = 32;
    localparam int ADDR_W          = 5;
    localparam int DATA_W          = 32;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
    } ws_bus_t;

    function automatic ws_bus_t unpack_ws_bus(input logic [WS_TO_RF_BUS_WD-1:0] raw);
        ws_bus_t b;
        b.we    = raw[WE_BIT];
        b.waddr = raw[WADDR_HI:WADDR_LO];
        b.wdata = raw[WDATA_HI:0];
        return b;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback-facing bundle of the register file: writeback bus, two read ports, issue and scoreboard status.
// master = pipeline side (decode + writeback), slave = register file.
interface regfile_scoreboard_if;
    import regfile_scoreboard_pkg::*;

    logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus;
    logic [ADDR_W-1:0]          raddr1;
    logic [DATA_W-1:0]          rdata1;
    logic [ADDR_W-1:0]          raddr2;
    logic [DATA_W-1:0]          rdata2;
    logic                       busy1;
    logic                       busy2;
    logic                       ds_issue;
    logic [ADDR_W-1:0]          ds_issue_dest;
    logic                       issue_ready;
    logic                       flush;
    logic                       sb_err;

    modport master (
        output ws_to_rf_bus, raddr1, raddr2, ds_issue, ds_issue_dest, flush,
        input  rdata1, rdata2, busy1, busy2, issue_ready, sb_err
    );

    modport slave (
        input  ws_to_rf_bus, raddr1, raddr2, ds_issue, ds_issue_dest, flush,
        output rdata1, rdata2, busy1, busy2, issue_ready, sb_err
    );
endinterface

// File: rtl/regfile_scoreboard_sb_counter.sv
// Pending-write counter for one register: up on issue, down on retire, cleared by flush.
// One cycle update latency; inc is pre-qualified by the caller so it never wraps, udf is a combinational pulse.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             udf
);

    // A retire with nothing pending is an error; flush cancels the retire's bookkeeping too.
    assign udf = dec && !inc && !clr && (cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// 32x32 register file with two combinational read ports (optional write bypass) and a per-register pending-write scoreboard.
// Writes land on the next edge; issue_ready drops when the destination's counter is saturated.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int CNT_W  = 2,
    parameter bit BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  rf
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    ws_bus_t           bus;
    logic [DATA_W-1:0] regs [REG_NUM];
    logic [CNT_W-1:0]  cnt  [REG_NUM];
    logic [REG_NUM-1:1] inc;
    logic [REG_NUM-1:1] dec;
    logic [REG_NUM-1:1] udf;
    logic              retire;
    logic              issue_acc;
    logic              sb_err_q;

    assign bus       = unpack_ws_bus(rf.ws_to_rf_bus);
    assign retire    = bus.we && (bus.waddr != '0);
    assign issue_acc = rf.ds_issue && rf.issue_ready && (rf.ds_issue_dest != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (retire) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    assign rf.rdata1 = (rf.raddr1 == '0) ? '0 :
                       (BYPASS && bus.we && (bus.waddr == rf.raddr1)) ? bus.wdata : regs[rf.raddr1];
    assign rf.rdata2 = (rf.raddr2 == '0) ? '0 :
                       (BYPASS && bus.we && (bus.waddr == rf.raddr2)) ? bus.wdata : regs[rf.raddr2];

    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            inc[r] = issue_acc && (rf.ds_issue_dest == ADDR_W'(r));
            dec[r] = retire && (bus.waddr == ADDR_W'(r));
        end
    end

    // r0 has no counter: it can never be pending.
    assign cnt[0] = '0;

    for (genvar r = 1; r < REG_NUM; r++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (inc[r]),
            .dec   (dec[r]),
            .clr   (rf.flush),
            .cnt   (cnt[r]),
            .udf   (udf[r])
        );
    end

    // Busy reflects registered counters, so a same-cycle retire still shows busy.
    assign rf.busy1       = (rf.raddr1 != '0) && (cnt[rf.raddr1] != '0);
    assign rf.busy2       = (rf.raddr2 != '0) && (cnt[rf.raddr2] != '0);
    assign rf.issue_ready = (cnt[rf.ds_issue_dest] != CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_err_q <= 1'b0;
        end else if (|udf) begin
            sb_err_q <= 1'b1;
        end
    end

    assign rf.sb_err = sb_err_q;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Receiving end of the writeback-to-register-file bus: 32x32 general register file, written by the writeback stage's {we, waddr, wdata} bus.
- Two combinational read ports serve the decode stage, with optional same-cycle write bypass.
- Per-register pending-write scoreboard: decode marks a destination in flight at issue, writeback retires it; decode reads busy flags to stall.

Parameters:
- WS_TO_RF_BUS_WD, 38, width of incoming bus: {we[37], waddr[36:32], wdata[31:0]}
- CNT_W, 2, width of each per-register pending counter; max in flight per register = 2^CNT_W-1
- BYPASS, 1, 1: read of a register being written this cycle returns wdata; 0: returns old contents

Ports:
- clk  input  1  core clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- ws_to_rf_bus  input  WS_TO_RF_BUS_WD  {rf_we, rf_waddr, rf_wdata} from writeback stage
- raddr1  input  5  read port 1 address
- rdata1  output  32  read port 1 data, combinational
- raddr2  input  5  read port 2 address
- rdata2  output  32  read port 2 data, combinational
- busy1  output  1  raddr1 has >=1 pending write
- busy2  output  1  raddr2 has >=1 pending write
- ds_issue  input  1  decode issues an instruction this cycle (qualified by issue_ready)
- ds_issue_dest  input  5  destination of issuing instruction; 0 = no destination
- issue_ready  output  1  low when counter of ds_issue_dest is saturated
- flush  input  1  synchronous clear of all pending counters (pipeline cancel)
- sb_err  output  1  sticky: writeback retired a register whose counter was 0

Behaviour:
- Reset (async): regs[1..31]=0, all counters=0, sb_err=0. Outputs after reset: rdata*=0, busy*=0, issue_ready=1.
- Register 0: never written (we with waddr=0 ignored), always reads 0, never busy, counter never increments; issue_ready=1 when ds_issue_dest=0.
- Write: on rising edge, if rf_we && rf_waddr!=0, regs[rf_waddr]<=rf_wdata. Zero write latency to the array.
- Read: rdataN = (raddrN==0) ? 0 : (BYPASS && rf_we && rf_waddr==raddrN) ? rf_wdata : regs[raddrN].
- Issue accepted = ds_issue && issue_ready && ds_issue_dest!=0. issue_ready = (cnt[ds_issue_dest] != 2^CNT_W-1).
- Retire = rf_we && rf_waddr!=0.
- Counter update per register r, per cycle:
  - accepted issue to r, no retire of r: cnt+1
  - retire of r, no issue to r: cnt-1 if cnt>0; if cnt==0, stays 0 and sb_err<=1
  - issue and retire same r same cycle: cnt unchanged, data written
  - neither: hold
- busyN = (cnt[raddrN]!=0) && raddrN!=0. Combinational from registered counters; a same-cycle retire does not clear busy until the next cycle. With BYPASS=1, decode may forward rdata when busy is due only to that retire; the stall decision belongs to decode.
- flush: all counters<=0 next edge, overriding issue/retire in that cycle. Register write in the same cycle still occurs. sb_err is unaffected.
- sb_err clears only on reset.
- Saturation: an issue with issue_ready=0 is not recorded; decode must hold the instruction.
- Reset asserted mid-operation clears everything asynchronously. In-flight writes after deassert retire against cnt=0 and set sb_err; the pipeline is reset together, so this does not occur in-system.

Decomposition:
- Shared header macros: WS_TO_RF_BUS_WD, bus field positions (37 / 36:32 / 31:0), REG_NUM=32.
- One natural sub-module, sb_counter: a single CNT_W saturating up/down counter with inc, dec, clr, and an underflow pulse. Instantiate 31 times, r1..r31; r0 is constant.

Test Plan:
- Reset then read all 32 registers -> rdata=0, busy=0, issue_ready=1, sb_err=0.
- rf_we=1, waddr=5, wdata=0xDEADBEEF, raddr1=5, BYPASS=1 -> same cycle rdata1=0xDEADBEEF; next cycle still 0xDEADBEEF. With BYPASS=0, same cycle returns old value 0.
- Write waddr=0, wdata=0x12345678 -> rdata of r0 stays 0. Issue dest=0 -> busy on r0 stays 0.
- Issue dest=7 three times -> cnt=3, issue_ready=0 for dest 7. A fourth issue is ignored. Three retires of r7 -> busy1 (raddr1=7) drops the cycle after the third retire.
- Issue dest=9 and retire r9 in the same cycle with cnt=1 -> cnt stays 1, busy stays 1, reg updated.
- Retire r3 with cnt=0 -> sb_err=1 and stays 1. Issue dest=4 twice, then flush -> busy for r4 clears next cycle. Async reset pulse mid-run -> all outputs return to reset values without a clock edge.
